// File: rtl/dmem_sram_ctrl_pkg.sv
// Shared types for the data-memory SRAM controller: FSM state encoding,
// counter width and the registered SRAM control bundle.
package dmem_sram_ctrl_pkg;

  localparam int DMEM_WAIT_W = 4;

  typedef enum logic [2:0] {
    DMEM_IDLE     = 3'd0,
    DMEM_RD       = 3'd1,
    DMEM_WR_SETUP = 3'd2,
    DMEM_WR_PULSE = 3'd3,
    DMEM_WR_HOLD  = 3'd4,
    DMEM_DONE     = 3'd5
  } dmem_state_e;

  typedef struct packed {
    logic       ce_n;
    logic       oe_n;
    logic       we_n;
    logic [3:0] be_n;
    logic       data_oe;
  } sram_ctl_t;

  localparam sram_ctl_t SRAM_CTL_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                          be_n: 4'b1111, data_oe: 1'b0};

  // Word access needs addr[1:0]==0; half-word lanes need an even address.
  function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                         input logic [3:0] wbe_n);
    logic bad;
    bad = 1'b0;
    if (wbe_n == 4'b0000 && addr_lo != 2'b00) bad = 1'b1;
    if ((wbe_n == 4'b1100 || wbe_n == 4'b0011) && addr_lo[0]) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/dmem_sram_ctrl_if.sv
// MEM-stage data interface between the pipeline (master) and the SRAM
// controller (slave). dm_misalign exists only with DMEM_MISALIGN_CHK_EN.
interface dmem_sram_ctrl_if;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wbe_n;
  logic [31:0] dm_wdata;
  logic        dm_re;
  logic        dm_we;
  logic [31:0] dm_rdata;
  logic        dm_stall;
`ifdef DMEM_MISALIGN_CHK_EN
  logic        dm_misalign;

  modport master (output dm_addr, dm_wbe_n, dm_wdata, dm_re, dm_we,
                  input  dm_rdata, dm_stall, dm_misalign);
  modport slave  (input  dm_addr, dm_wbe_n, dm_wdata, dm_re, dm_we,
                  output dm_rdata, dm_stall, dm_misalign);
`else
  modport master (output dm_addr, dm_wbe_n, dm_wdata, dm_re, dm_we,
                  input  dm_rdata, dm_stall);
  modport slave  (input  dm_addr, dm_wbe_n, dm_wdata, dm_re, dm_we,
                  output dm_rdata, dm_stall);
`endif
endinterface

// File: rtl/dmem_sram_ctrl.sv
// Data-memory responder: runs one load/store at a time on an async 32-bit SRAM
// and stalls MEM until done. Optional alignment check: DMEM_MISALIGN_CHK_EN.
module dmem_sram_ctrl
  import dmem_sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  dmem_sram_ctrl_if.slave   dm,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  input  logic [31:0]       sram_rdata_i,
  output logic              sram_data_oe_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [3:0]        sram_be_n_o
);

  localparam logic [DMEM_WAIT_W-1:0] WAIT_INIT = DMEM_WAIT_W'(WAIT_CYCLES);

  dmem_state_e             state_q, state_d;
  logic [DMEM_WAIT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [3:0]              wbe_n_q, wbe_n_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  sram_ctl_t               ctl_q, ctl_d;

  logic wr_req, rd_req, bad_align;

  assign wr_req = dm.dm_we & (dm.dm_wbe_n != 4'b1111);
  assign rd_req = dm.dm_re & ~wr_req;

`ifdef DMEM_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;
  assign bad_align      = is_misaligned(dm.dm_addr[1:0], dm.dm_wbe_n);
  assign dm.dm_misalign = misalign_q;
  logic unused_addr;
  assign unused_addr = ^dm.dm_addr[31:ADDR_W+2];
`else
  assign bad_align = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{dm.dm_addr[31:ADDR_W+2], dm.dm_addr[1:0]};
`endif

  assign dm.dm_stall = ((state_q == DMEM_IDLE) & (wr_req | rd_req)) |
                       ((state_q != DMEM_IDLE) & (state_q != DMEM_DONE));

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wbe_n_d = wbe_n_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ctl_d   = SRAM_CTL_IDLE;
`ifdef DMEM_MISALIGN_CHK_EN
    misalign_d = 1'b0;
`endif

    unique case (state_q)
      DMEM_IDLE: begin
        if (wr_req | rd_req) begin
          if (bad_align) begin
            state_d = DMEM_DONE;
`ifdef DMEM_MISALIGN_CHK_EN
            misalign_d = 1'b1;
`endif
          end else begin
            addr_d  = dm.dm_addr[ADDR_W+1:2];
            wbe_n_d = dm.dm_wbe_n;
            wdata_d = dm.dm_wdata;
            cnt_d   = WAIT_INIT;
            state_d = rd_req ? DMEM_RD : DMEM_WR_SETUP;
          end
        end
      end
      DMEM_RD: begin
        if (cnt_q == '0) begin
          rdata_d = sram_rdata_i;
          state_d = DMEM_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DMEM_WR_SETUP: begin
        cnt_d   = WAIT_INIT;
        state_d = DMEM_WR_PULSE;
      end
      DMEM_WR_PULSE: begin
        if (cnt_q == '0) state_d = DMEM_WR_HOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DMEM_WR_HOLD: state_d = DMEM_DONE;
      DMEM_DONE:    state_d = DMEM_IDLE;
      default:      state_d = DMEM_IDLE;
    endcase

    // Strobes are decoded from the next state and registered, so the SRAM
    // pins come straight from flops and never glitch.
    unique case (state_d)
      DMEM_RD:
        ctl_d = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1, be_n: 4'b0000, data_oe: 1'b0};
      DMEM_WR_SETUP, DMEM_WR_HOLD:
        ctl_d = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1, be_n: wbe_n_d, data_oe: 1'b1};
      DMEM_WR_PULSE:
        ctl_d = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0, be_n: wbe_n_d, data_oe: 1'b1};
      default:
        ctl_d = SRAM_CTL_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wbe_n_q <= 4'b1111;
      wdata_q <= '0;
      rdata_q <= '0;
      ctl_q   <= SRAM_CTL_IDLE;
`ifdef DMEM_MISALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wbe_n_q <= wbe_n_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ctl_q   <= ctl_d;
`ifdef DMEM_MISALIGN_CHK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign sram_addr_o    = addr_q;
  assign sram_wdata_o   = wdata_q;
  assign sram_data_oe_o = ctl_q.data_oe;
  assign sram_ce_n_o    = ctl_q.ce_n;
  assign sram_oe_n_o    = ctl_q.oe_n;
  assign sram_we_n_o    = ctl_q.we_n;
  assign sram_be_n_o    = ctl_q.be_n;
  assign dm.dm_rdata    = rdata_q;

endmodule

// File: tb/tb_dmem_sram_ctrl.sv
// Directed bench for dmem_sram_ctrl with a behavioural async SRAM and a
// queue of expected dm_rdata values checked at each access's DONE cycle.
module tb_dmem_sram_ctrl;

  localparam int ADDR_W = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata, sram_rdata;
  logic              sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]        sram_be_n;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mem [0:255];

  // Results of the most recent access, filled by do_access.
  int          lat, oe_cnt, we_cnt, doe_cnt, ce_cnt;
  logic [ADDR_W-1:0] addr_seen;
  logic [3:0]  be_seen;
  logic        mis_seen;

  dmem_sram_ctrl_if bus ();

  dmem_sram_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .dm             (bus),
    .sram_addr_o    (sram_addr),
    .sram_wdata_o   (sram_wdata),
    .sram_rdata_i   (sram_rdata),
    .sram_data_oe_o (sram_data_oe),
    .sram_ce_n_o    (sram_ce_n),
    .sram_oe_n_o    (sram_oe_n),
    .sram_we_n_o    (sram_we_n),
    .sram_be_n_o    (sram_be_n)
  );

  always #5 clk = ~clk;

  // Shared data bus as the board would build it, plus the SRAM array.
  wire [31:0] sram_data = sram_data_oe ? sram_wdata : 32'bz;
  assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n)
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_data[8*b +: 8];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one request right after a rising edge, follows it to DONE and
  // records strobe activity; the expected dm_rdata is queued up front.
  task automatic do_access(input logic re, input logic we, input logic [31:0] addr,
                           input logic [3:0] wbe_n, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata);
    bit done;
    bus.dm_re = re; bus.dm_we = we; bus.dm_addr = addr;
    bus.dm_wbe_n = wbe_n; bus.dm_wdata = wdata;
    exp_q.push_back(exp_rdata);
    lat = 0; oe_cnt = 0; we_cnt = 0; doe_cnt = 0; ce_cnt = 0;
    addr_seen = '0; be_seen = 4'b1111; mis_seen = 1'b0; done = 0;
    @(negedge clk);
    check("stall_on_request", 32'(bus.dm_stall), 32'd1);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!sram_ce_n) begin
        if (ce_cnt == 0) addr_seen = sram_addr;
        ce_cnt++;
      end
      if (!sram_oe_n) oe_cnt++;
      if (!sram_we_n) begin we_cnt++; be_seen = sram_be_n; end
      if (sram_data_oe) doe_cnt++;
      if (!bus.dm_stall) begin
        done = 1;
`ifdef DMEM_MISALIGN_CHK_EN
        mis_seen = bus.dm_misalign;
`endif
      end
    end
    if (exp_q.size() == 0) check("scoreboard_empty", 32'd0, 32'd1);
    else check("rdata_at_done", bus.dm_rdata, exp_q.pop_front());
    @(posedge clk); #1;
    bus.dm_re = 1'b0; bus.dm_we = 1'b0; bus.dm_wbe_n = 4'b1111;
  endtask

  initial begin
    int act;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | i;
    mem[8'h41] = 32'hDEADBEEF;
    rst = 1'b1;
    bus.dm_re = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0;
    bus.dm_wbe_n = 4'b1111; bus.dm_wdata = '0;

    // Reset state
    repeat (3) begin
      @(negedge clk);
      check("rst_strobes", {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe}, 32'hE);
      check("rst_be_n", 32'(sram_be_n), 32'hF);
      check("rst_stall_rdata", {bus.dm_rdata[30:0], bus.dm_stall} | 32'(bus.dm_rdata[31]), 32'd0);
      check("rst_addr_wdata", 32'(sram_addr) | sram_wdata, 32'd0);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Load, WAIT_CYCLES=1
    do_access(1'b1, 1'b0, 32'h0000_0104, 4'b0000, 32'h0, 32'hDEADBEEF);
    check("ld_latency", lat, 3);
    check("ld_addr", 32'(addr_seen), 32'h41);
    check("ld_oe_cycles", oe_cnt, 2);
    check("ld_no_we", we_cnt + doe_cnt, 0);
`ifdef DMEM_MISALIGN_CHK_EN
    check("ld_no_misalign", 32'(mis_seen), 32'd0);
`endif

    // Byte store to lane 3; rdata must be untouched
    do_access(1'b0, 1'b1, 32'h0000_0203, 4'b0111, 32'h5A00_0000, 32'hDEADBEEF);
    check("st_latency", lat, 5);
    check("st_addr", 32'(addr_seen), 32'h80);
    check("st_be_n", 32'(be_seen), 32'h7);
    check("st_we_cycles", we_cnt, 2);
    check("st_data_oe_cycles", doe_cnt, 4);
    check("st_ce_cycles", ce_cnt, 4);
    check("st_no_oe", oe_cnt, 0);
    check("st_mem_word", mem[8'h80], 32'h5ADE0080);

    // Store with no byte lanes is a no-op
    bus.dm_we = 1'b1; bus.dm_wbe_n = 4'b1111;
    bus.dm_addr = 32'h0000_0300; bus.dm_wdata = 32'hFFFF_FFFF;
    act = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.dm_stall || !sram_ce_n || !sram_we_n || sram_data_oe) act++;
    end
    check("noop_activity", act, 0);
    check("noop_mem", mem[8'hC0], 32'hC0DE00C0);
    bus.dm_we = 1'b0;
    @(posedge clk); #1;

    // Store then load back to back, same word
    do_access(1'b0, 1'b1, 32'h0000_0010, 4'b0000, 32'h1234_5678, 32'hDEADBEEF);
    check("b2b_st_latency", lat, 5);
    do_access(1'b1, 1'b0, 32'h0000_0010, 4'b0000, 32'h0, 32'h1234_5678);
    check("b2b_ld_latency", lat, 3);
    check("b2b_ld_addr", 32'(addr_seen), 32'h4);

    // Read and write together: write wins
    do_access(1'b1, 1'b1, 32'h0000_0014, 4'b1100, 32'h0000_ABCD, 32'h1234_5678);
    check("rw_is_write", lat, 5);
    check("rw_mem", mem[8'h05], 32'hC0DEABCD);

    // Upper address bits alias
    do_access(1'b1, 1'b0, 32'hFFC0_0104, 4'b0000, 32'h0, 32'hDEADBEEF);
    check("wrap_addr", 32'(addr_seen), 32'h41);

`ifdef DMEM_MISALIGN_CHK_EN
    do_access(1'b1, 1'b0, 32'h0000_0002, 4'b0000, 32'h0, 32'hDEADBEEF);
    check("mis_latency", lat, 1);
    check("mis_flag", 32'(mis_seen), 32'd1);
    check("mis_no_strobes", ce_cnt + doe_cnt, 0);
    @(negedge clk);
    check("mis_flag_one_cycle", 32'(bus.dm_misalign), 32'd0);
    @(posedge clk); #1;
`endif

    // Reset in the middle of the write pulse
    bus.dm_we = 1'b1; bus.dm_wbe_n = 4'b0000;
    bus.dm_addr = 32'h0000_0020; bus.dm_wdata = 32'hAAAA_5555;
    act = 0;
    do begin
      @(negedge clk);
      act++;
    end while (sram_we_n && act < 20);
    check("abort_reached_pulse", 32'(sram_we_n), 32'd0);
    rst = 1'b1; bus.dm_we = 1'b0; bus.dm_wbe_n = 4'b1111;
    @(negedge clk);
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    check("abort_data_oe", {31'd0, sram_data_oe}, 32'd0);
    check("abort_ce_n", 32'(sram_ce_n), 32'd1);
    check("abort_stall", 32'(bus.dm_stall), 32'd0);
    check("abort_rdata", bus.dm_rdata, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    do_access(1'b1, 1'b0, 32'h0000_0104, 4'b0000, 32'h0, 32'hDEADBEEF);
    check("post_abort_latency", lat, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
